byte_pair_packer: RTL and testbench
===================================

BYTE_PAIR_PACKER -- requirements
Module: byte_pair_packer

Interface
REQ-001 SHALL have parameter SWAP, default 0, meaning: 0 = first byte of a pair goes to field a; 1 = first byte goes to field b.
REQ-002 SHALL have parameter CNT_W, default 8, meaning: width of pair_count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, upstream byte valid.
REQ-006 SHALL have port in_data, input, 8 (byte), upstream byte.
REQ-007 SHALL have port in_ready, output, 1, packer accepts in_data this cycle.
REQ-008 SHALL have port out_valid, output, 1, out_data holds a complete pair.
REQ-009 SHALL have port out_data, output, 16 (p::p_t), packed pair {a, b}.
REQ-010 SHALL have port out_ready, input, 1, downstream consumes out_data this cycle.
REQ-011 SHALL have port flush, input, 1, discard a half-assembled pair.
REQ-012 SHALL have port pair_count, output, CNT_W, number of pairs delivered, modulo 2^CNT_W.

Function
REQ-013 SHALL treat an input transfer as in_valid && in_ready at a rising edge, and an output transfer as out_valid && out_ready at a rising edge.
REQ-014 SHALL hold a 1-byte hold register (hold_valid) and a 16-bit output register (out_valid); state = {out_valid, hold_valid}: EMPTY, HALF, FULL, FULL_HALF.
REQ-015 SHALL drive in_ready = !hold_valid || !out_valid || out_ready, combinationally; in_ready SHALL NOT depend on in_valid.
REQ-016 SHALL, on an input transfer with hold_valid=0, store in_data in hold and set hold_valid.
REQ-017 SHALL, on an input transfer with hold_valid=1, load out_data with first=hold and second=in_data, set out_valid, and clear hold_valid, all in the same edge; latency is 1 cycle from the second byte to out_valid.
REQ-018 SHALL map first/second to a/b when SWAP=0 and to b/a when SWAP=1.
REQ-019 SHALL clear out_valid on an output transfer unless REQ-017 reloads it in the same edge; a simultaneous load and unload SHALL leave out_valid=1 with the new pair.
REQ-020 SHALL hold out_data stable while out_valid=1 and out_ready=0.
REQ-021 SHALL increment pair_count by 1 on each output transfer and wrap from 2^CNT_W-1 to 0.
REQ-022 SHALL, on flush=1, clear hold_valid and ignore any input transfer in that cycle (in_ready forced 0); out_valid and out_data are unaffected and an output transfer in that cycle completes normally.
REQ-023 SHALL treat state transitions as: EMPTY->HALF (byte in); HALF->FULL (byte in); FULL->EMPTY (out only); FULL->FULL_HALF (byte in, no out); FULL->HALF (byte in and out); FULL_HALF->FULL (byte in and out); FULL_HALF stays while out_ready=0.

Reset
REQ-024 SHALL, while rst=1, asynchronously force hold_valid=0, out_valid=0, out_data=16'h0000, and pair_count=0.
REQ-025 SHALL keep in_ready=0 while rst=1; a pair half-assembled when reset asserts SHALL be lost.
REQ-026 SHALL accept the first byte on the first rising edge after rst deasserts.

Structure
REQ-027 SHALL take p_t (packed struct: byte a, byte b) from package p; the 2-bit state enum typedef SHALL also live in package p.
REQ-028 SHALL be a single module with no sub-module; output is intended to connect directly to a p::p_t input port.

Verification
REQ-029 Bench SHALL cover: reset then bytes 8'hAA, 8'h55 with out_ready=1 -> out_valid one cycle after 8'h55, out_data.a=8'hAA, out_data.b=8'h55, pair_count=1.
REQ-030 Bench SHALL cover: SWAP=1, bytes 8'hBB, 8'h66 -> a=8'h66, b=8'hBB.
REQ-031 Bench SHALL cover: out_ready=0, bytes 11,22,33 -> state FULL_HALF, in_ready=0, out_data stays {11,22}; raise out_ready with byte 44 -> next out_data {33,44}.
REQ-032 Bench SHALL cover: byte 8'h12, then flush, then bytes 8'h34, 8'h56 -> single pair {34,56}, 12 never appears.
REQ-033 Bench SHALL cover: CNT_W=2, 5 pairs delivered -> pair_count sequence 1,2,3,0,1.
REQ-034 Bench SHALL cover: rst asserted mid-pair (HALF) and while out_valid=1 -> out_valid=0 and pair_count=0 immediately without a clock edge; the next two bytes form a fresh pair.

Source files
------------

// File: rtl/byte_pair_packer_pkg.sv
// Package p: shared types for the byte pair packer.
//   p_t      - packed output pair {a, b}, 16 bits, a in the upper byte
//   state_e  - packer occupancy, encoded as {out_valid, hold_valid}
//   make_pair- places first/second bytes into a/b according to swap
package p;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } p_t;

  // Encoding is exactly {out_valid, hold_valid} so the state can be
  // rebuilt from the two valid flops with a cast.
  typedef enum logic [1:0] {
    ST_EMPTY     = 2'b00,
    ST_HALF      = 2'b01,
    ST_FULL      = 2'b10,
    ST_FULL_HALF = 2'b11
  } state_e;

  function automatic p_t make_pair(input logic swap,
                                   input logic [7:0] first,
                                   input logic [7:0] second);
    p_t r;
    if (swap) begin
      r.a = second;
      r.b = first;
    end else begin
      r.a = first;
      r.b = second;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_pair_packer.sv
// byte_pair_packer: collects two upstream bytes into one 16-bit pair.
// A one-byte hold register plus a pair output register give a two-deep
// buffer, so a full rate byte stream is sustained when out_ready stays
// high.
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_data    - upstream byte stream
//   in_ready            - byte accepted this cycle (combinational)
//   out_valid/out_data  - completed pair, held stable until consumed
//   out_ready           - downstream consumes the pair
//   flush               - drop a half-assembled pair, block input
//   pair_count          - pairs delivered, wraps at 2^CNT_W
module byte_pair_packer
  import p::*;
#(
  parameter int SWAP  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             out_valid,
  output p_t               out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [CNT_W-1:0] pair_count
);

  logic             hold_valid_q, hold_valid_d;
  logic [7:0]       hold_q, hold_d;
  logic             out_valid_q, out_valid_d;
  p_t               out_data_q, out_data_d;
  logic [CNT_W-1:0] pair_count_q, pair_count_d;

  state_e state;
  logic   in_xfer;
  logic   out_xfer;
  logic   load;

  assign state = state_e'({out_valid_q, hold_valid_q});

  // Only FULL_HALF has nowhere to put a new byte, unless the pair
  // register drains on the same edge. Reset and flush block input.
  assign in_ready = !rst && !flush && ((state != ST_FULL_HALF) || out_ready);

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;
  // Second byte of a pair: it completes the pair with the held byte.
  assign load     = in_xfer && hold_valid_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    pair_count_d = pair_count_q;

    if (out_xfer) begin
      out_valid_d  = 1'b0;
      pair_count_d = pair_count_q + CNT_W'(1);
    end

    if (flush) begin
      // in_xfer is already 0 here since flush forces in_ready low.
      hold_valid_d = 1'b0;
    end else if (load) begin
      // Load wins over the unload above: out_valid stays high with the
      // new pair.
      out_data_d   = make_pair(SWAP != 0, hold_q, in_data);
      out_valid_d  = 1'b1;
      hold_valid_d = 1'b0;
    end else if (in_xfer) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= 8'h00;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      pair_count_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      pair_count_q <= pair_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign pair_count = pair_count_q;

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed bench for byte_pair_packer. Three instances share one input
// stream: u0 default, u1 with SWAP=1, u2 with CNT_W=2.
module tb_byte_pair_packer;
  import p::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_ready = 1'b0;
  logic       flush = 1'b0;

  logic       rdy0, rdy1, rdy2;
  logic       ov0, ov1, ov2;
  p_t         od0, od1, od2;
  logic [7:0] pc0, pc1;
  logic [1:0] pc2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  byte_pair_packer #(.SWAP(0), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0),
    .out_ready(out_ready), .flush(flush), .pair_count(pc0));

  byte_pair_packer #(.SWAP(1), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1),
    .out_ready(out_ready), .flush(flush), .pair_count(pc1));

  byte_pair_packer #(.SWAP(0), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy2), .out_valid(ov2), .out_data(od2),
    .out_ready(out_ready), .flush(flush), .pair_count(pc2));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one edge; returns #1 after that edge.
  task automatic push(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset values, no edge yet
    #3;
    chk("rst_ov", ov0, 0);
    chk("rst_pc", pc0, 0);
    chk("rst_od", od0, 0);
    chk("rst_rdy", rdy0, 0);
    idle(); idle();
    rst = 1'b0;

    // Basic pair AA,55
    out_ready = 1'b1;
    push(8'hAA);
    chk("t1_ov_half", ov0, 0);
    push(8'h55);
    chk("t1_ov", ov0, 1);
    chk("t1_od", od0, 16'hAA55);
    chk("t1_od_swap", od1, 16'h55AA);
    idle();
    chk("t1_ov_drain", ov0, 0);
    chk("t1_pc", pc0, 1);
    chk("t1_pc2", pc2, 1);

    // SWAP: BB,66 -> a=66 b=BB
    push(8'hBB);
    push(8'h66);
    chk("t2_swap_a", od1.a, 8'h66);
    chk("t2_swap_b", od1.b, 8'hBB);
    chk("t2_od", od0, 16'hBB66);
    idle();
    chk("t2_pc2", pc2, 2);

    // Backpressure: 11,22,33 with out_ready=0
    out_ready = 1'b0;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    chk("t3_state", u0.state, ST_FULL_HALF);
    chk("t3_ov", ov0, 1);
    chk("t3_od", od0, 16'h1122);
    in_valid = 1'b1;
    in_data  = 8'h44;
    #1;
    chk("t3_rdy_blocked", rdy0, 0);
    idle();
    chk("t3_od_hold", od0, 16'h1122);
    chk("t3_pc_hold", pc0, 2);
    out_ready = 1'b1;
    #1;
    chk("t3_rdy_open", rdy0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t3_ov_reload", ov0, 1);
    chk("t3_od_new", od0, 16'h3344);
    chk("t3_pc2", pc2, 3);
    idle();
    chk("t3_ov_drain", ov0, 0);
    chk("t3_pc2_wrap", pc2, 0);
    chk("t3_pc", pc0, 4);

    // Flush drops the held 12; EE offered during flush is ignored
    push(8'h12);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    #1;
    chk("t4_rdy_flush", rdy0, 0);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("t4_state", u0.state, ST_EMPTY);
    push(8'h34);
    chk("t4_ov_half", ov0, 0);
    push(8'h56);
    chk("t4_od", od0, 16'h3456);
    idle();
    chk("t4_pc2", pc2, 1);
    chk("t4_ov_drain", ov0, 0);

    // Async reset with a pair pending and a byte held
    out_ready = 1'b0;
    push(8'h77);
    push(8'h88);
    push(8'h99);
    chk("t5_state", u0.state, ST_FULL_HALF);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_ov", ov0, 0);
    chk("t5_rst_pc", pc0, 0);
    chk("t5_rst_od", od0, 0);
    chk("t5_rst_rdy", rdy0, 0);
    idle();
    rst = 1'b0;
    out_ready = 1'b1;
    push(8'hA1);
    chk("t5_ov_half", ov0, 0);
    push(8'hB2);
    chk("t5_ov", ov0, 1);
    chk("t5_od", od0, 16'hA1B2);
    idle();
    chk("t5_pc", pc0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
